// File: rtl/uart_rx_buffered_if.sv
// Host-side read port of the UART receive FIFO: pop request plus head data and level/status.
interface uart_rx_buffered_if #(parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_rd_en;
  logic [7:0]    o_rd_data;
  logic          o_empty;
  logic          o_full;
  logic          o_almostfull;
  logic          o_almostempty;
  logic          o_underflow;
  logic [CW-1:0] o_count;

  modport master (
    output i_rd_en,
    input  o_rd_data, o_empty, o_full, o_almostfull, o_almostempty, o_underflow, o_count
  );
  modport slave (
    input  i_rd_en,
    output o_rd_data, o_empty, o_full, o_almostfull, o_almostempty, o_underflow, o_count
  );
endinterface

// File: rtl/uart_rx_buffered.sv
// UART receiver (8 data bits, optional parity, 1 stop) feeding a first-word-fall-through FIFO.
// Define UART_RX_MAJORITY_VOTE_EN for 3-sample majority voting on every bit decision.
module uart_rx_buffered #(
  parameter int DEPTH            = 16,
  parameter int ALMOST_FULL_THR  = 14,
  parameter int ALMOST_EMPTY_THR = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rx,
  input  logic [15:0]        baud_divisor,
  input  logic [1:0]         i_parity_type,
  uart_rx_buffered_if.slave  rd,
  output logic               o_framing_error,
  output logic               o_parity_error,
  output logic               o_overrun_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t        state, state_nx;
  logic          rx_m, rx_s, bit_v;
  logic [15:0]   cnt, div_q, target;
  logic [1:0]    par_q;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad, par_en, tick;
  logic          wr_req, we, pop_ok, space_ok;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision lands one cycle after the nominal point so all three samples exist.
  localparam logic [15:0] VOTE_LAG = 16'd1;
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rx_s};
  end
  assign bit_v = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  localparam logic [15:0] VOTE_LAG = 16'd0;
  assign bit_v = rx_s;
`endif

  assign par_en = par_q[0] ^ par_q[1];
  assign target = (state == START) ? (div_q >> 1) - 16'd1 + VOTE_LAG : div_q - 16'd1;
  assign tick   = (cnt == target);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    wr_req          = 1'b0;
    o_framing_error = 1'b0;
    o_parity_error  = 1'b0;
    o_overrun_error = 1'b0;
    case (state)
      IDLE:      if (!rx_s) state_nx = START;
      START:     if (tick) state_nx = bit_v ? IDLE : DATA;
      DATA:      if (tick && bit_idx == 3'd7) state_nx = par_en ? PARITY : STOP;
      PARITY:    if (tick) state_nx = STOP;
      STOP: begin
        if (tick) begin
          if (!bit_v) begin
            o_framing_error = 1'b1;
            state_nx        = WAIT_IDLE;
          end else begin
            wr_req          = 1'b1;
            o_overrun_error = !space_ok;
            o_parity_error  = par_bad;
            state_nx        = IDLE;
          end
        end
      end
      WAIT_IDLE: if (rx_s) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Bit timing and frame datapath; config is frozen at start detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      div_q   <= '0;
      par_q   <= '0;
    end else if (state == IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
      par_bad <= 1'b0;
      if (!rx_s) begin
        div_q <= baud_divisor;
        par_q <= i_parity_type;
      end
    end else if (tick) begin
      cnt <= '0;
      if (state == DATA) begin
        shreg   <= {bit_v, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == PARITY) par_bad <= ^{shreg, bit_v, par_q[1]};
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // A pop on an empty FIFO is an underflow, so it never frees space for a write.
  assign pop_ok   = rd.i_rd_en && (count != '0);
  assign space_ok = (count != CW'(DEPTH)) || pop_ok;
  assign we       = wr_req && space_ok;

  always_ff @(posedge clk) begin
    if (!rst && we) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (we)     wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({we, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd.o_rd_data     = (count == '0) ? 8'h00 : mem[rd_ptr];
  assign rd.o_empty       = (count == '0);
  assign rd.o_full        = (count == CW'(DEPTH));
  assign rd.o_almostfull  = (count >= CW'(ALMOST_FULL_THR));
  assign rd.o_almostempty = (count != '0) && (count <= CW'(ALMOST_EMPTY_THR));
  assign rd.o_underflow   = rd.i_rd_en && (count == '0);
  assign rd.o_count       = count;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: frames are bit-banged on i_rx, FIFO drained through the interface.
module tb_uart_rx_buffered;
  logic        clk = 1'b0;
  logic        rst, i_rx;
  logic [15:0] baud_divisor;
  logic [1:0]  i_parity_type;
  logic        fe, pe, oe;
  int pass_cnt = 0, total = 0;
  int n_fe = 0, n_pe = 0, n_oe = 0;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int POP_OFS = 11;
`else
  localparam int POP_OFS = 10;
`endif

  uart_rx_buffered_if #(.DEPTH(16)) rd_if ();

  uart_rx_buffered #(.DEPTH(16), .ALMOST_FULL_THR(14), .ALMOST_EMPTY_THR(1)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx), .baud_divisor(baud_divisor),
    .i_parity_type(i_parity_type), .rd(rd_if),
    .o_framing_error(fe), .o_parity_error(pe), .o_overrun_error(oe)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled late in the low phase after inputs have settled.
  always @(negedge clk) begin
    #4;
    if (fe) n_fe++;
    if (pe) n_pe++;
    if (oe) n_oe++;
  end

  task automatic bit_t(input logic v);
    i_rx = v;
    repeat (int'(baud_divisor)) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic flip, input logic stop);
    logic p;
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(d[i]);
    if (i_parity_type == 2'b01 || i_parity_type == 2'b10) begin
      p = (^d) ^ (i_parity_type == 2'b10) ^ flip;
      bit_t(p);
    end
    bit_t(stop);
  endtask

  task automatic pop();
    rd_if.i_rd_en = 1'b1;
    @(negedge clk);
    rd_if.i_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_rx = 1'b1; rd_if.i_rd_en = 1'b0;
    baud_divisor = 16'd16; i_parity_type = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (rd_if.o_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", rd_if.o_empty); else pass_cnt++;
    total++; if (rd_if.o_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", rd_if.o_count); else pass_cnt++;
    total++; if (rd_if.o_rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_if.o_rd_data); else pass_cnt++;
    total++; if ({rd_if.o_full, rd_if.o_almostfull, rd_if.o_almostempty, rd_if.o_underflow} !== 4'b0000)
      $display("FAIL reset_status: got %b want 0000", {rd_if.o_full, rd_if.o_almostfull, rd_if.o_almostempty, rd_if.o_underflow});
    else pass_cnt++;
    total++; if ({fe, pe, oe} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {fe, pe, oe}); else pass_cnt++;
  endtask

  task automatic test_loopback();
    logic [7:0] v [4];
    int fe0, pe0, oe0;
    v[0] = 8'hA5; v[1] = 8'h3C; v[2] = 8'hFF; v[3] = 8'h00;
    fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
    baud_divisor = 16'd434; i_parity_type = 2'b01;
    for (int i = 0; i < 4; i++) send(v[i], 1'b0, 1'b1);
    bit_t(1'b1);
    total++; if (rd_if.o_count !== 5'd4) $display("FAIL loop_count: got %0d want 4", rd_if.o_count); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_if.o_rd_data !== v[i]) $display("FAIL loop_byte%0d: got %h want %h", i, rd_if.o_rd_data, v[i]);
      else pass_cnt++;
      pop();
    end
    total++; if (rd_if.o_empty !== 1'b1) $display("FAIL loop_drained: empty=%b want 1", rd_if.o_empty); else pass_cnt++;
    total++; if ({n_fe - fe0, n_pe - pe0, n_oe - oe0} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL loop_errors: fe=%0d pe=%0d oe=%0d want 0 0 0", n_fe - fe0, n_pe - pe0, n_oe - oe0);
    else pass_cnt++;
  endtask

  task automatic test_parity();
    int pe0;
    pe0 = n_pe;
    baud_divisor = 16'd16; i_parity_type = 2'b10;
    send(8'h01, 1'b1, 1'b1);
    bit_t(1'b1);
    total++; if (n_pe - pe0 !== 1) $display("FAIL parity_pulse: got %0d pulses want 1", n_pe - pe0); else pass_cnt++;
    total++; if (rd_if.o_count !== 5'd1) $display("FAIL parity_count: got %0d want 1", rd_if.o_count); else pass_cnt++;
    total++; if (rd_if.o_almostempty !== 1'b1) $display("FAIL parity_almostempty: got %b want 1", rd_if.o_almostempty); else pass_cnt++;
    total++; if (rd_if.o_rd_data !== 8'h01) $display("FAIL parity_byte: got %h want 01", rd_if.o_rd_data); else pass_cnt++;
    pop();
  endtask

  task automatic test_framing_break();
    int fe0, pe0, oe0;
    fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
    baud_divisor = 16'd16; i_parity_type = 2'b00;
    send(8'h55, 1'b0, 1'b0);
    i_rx = 1'b0;
    repeat (40 * 16) @(negedge clk);
    total++; if (n_fe - fe0 !== 1) $display("FAIL framing_pulse: got %0d pulses want 1", n_fe - fe0); else pass_cnt++;
    total++; if (rd_if.o_empty !== 1'b1) $display("FAIL framing_empty: empty=%b want 1", rd_if.o_empty); else pass_cnt++;
    bit_t(1'b1); bit_t(1'b1);
    send(8'h12, 1'b0, 1'b1);
    bit_t(1'b1);
    total++; if (rd_if.o_count !== 5'd1) $display("FAIL framing_next_count: got %0d want 1", rd_if.o_count); else pass_cnt++;
    total++; if (rd_if.o_rd_data !== 8'h12) $display("FAIL framing_next_byte: got %h want 12", rd_if.o_rd_data); else pass_cnt++;
    total++; if ({n_fe - fe0, n_pe - pe0, n_oe - oe0} !== {32'd1, 32'd0, 32'd0})
      $display("FAIL framing_flags: fe=%0d pe=%0d oe=%0d want 1 0 0", n_fe - fe0, n_pe - pe0, n_oe - oe0);
    else pass_cnt++;
    pop();
  endtask

  task automatic test_false_start();
    int fe0;
    fe0 = n_fe;
    baud_divisor = 16'd16; i_parity_type = 2'b00;
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    i_rx = 1'b1;
    repeat (20 * 16) @(negedge clk);
    total++; if (rd_if.o_count !== 5'd0) $display("FAIL false_start_count: got %0d want 0", rd_if.o_count); else pass_cnt++;
    total++; if (n_fe - fe0 !== 0) $display("FAIL false_start_flag: got %0d framing pulses want 0", n_fe - fe0); else pass_cnt++;
`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-cycle dip centred on bit 2's sample point; the vote must out-rule it.
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        i_rx = 1'b1; repeat (8) @(negedge clk);
        i_rx = 1'b0; @(negedge clk);
        i_rx = 1'b1; repeat (7) @(negedge clk);
      end else bit_t(logic'((8'hA5 >> i) & 8'h01));
    end
    bit_t(1'b1); bit_t(1'b1);
    total++; if (rd_if.o_rd_data !== 8'hA5) $display("FAIL glitch_byte: got %h want a5", rd_if.o_rd_data); else pass_cnt++;
    pop();
`endif
  endtask

  task automatic test_overrun();
    int oe0;
    baud_divisor = 16'd16; i_parity_type = 2'b00;
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0, 1'b1);
    total++; if ({rd_if.o_full, rd_if.o_almostfull} !== 2'b11) $display("FAIL overrun_full: full/af=%b want 11", {rd_if.o_full, rd_if.o_almostfull}); else pass_cnt++;
    total++; if (rd_if.o_count !== 5'd16) $display("FAIL overrun_count16: got %0d want 16", rd_if.o_count); else pass_cnt++;
    oe0 = n_oe;
    send(8'h50, 1'b0, 1'b1);
    total++; if (n_oe - oe0 !== 1) $display("FAIL overrun_pulse: got %0d pulses want 1", n_oe - oe0); else pass_cnt++;
    total++; if (rd_if.o_count !== 5'd16) $display("FAIL overrun_count_hold: got %0d want 16", rd_if.o_count); else pass_cnt++;
    total++; if (rd_if.o_rd_data !== 8'h40) $display("FAIL overrun_head: got %h want 40", rd_if.o_rd_data); else pass_cnt++;
    pop();
    send(8'h60, 1'b0, 1'b1);
    oe0 = n_oe;
    // Frame whose stop-bit write lands on the same clock as a pop.
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(logic'((8'h61 >> i) & 8'h01));
    i_rx = 1'b1;
    repeat (POP_OFS) @(negedge clk);
    rd_if.i_rd_en = 1'b1;
    @(negedge clk);
    rd_if.i_rd_en = 1'b0;
    repeat (16 - POP_OFS - 1) @(negedge clk);
    total++; if (n_oe - oe0 !== 0) $display("FAIL fullpop_overrun: got %0d pulses want 0", n_oe - oe0); else pass_cnt++;
    total++; if (rd_if.o_count !== 5'd16) $display("FAIL fullpop_count: got %0d want 16", rd_if.o_count); else pass_cnt++;
    total++; if (rd_if.o_rd_data !== 8'h42) $display("FAIL fullpop_head: got %h want 42", rd_if.o_rd_data); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int fe0;
    baud_divisor = 16'd16; i_parity_type = 2'b00;
    bit_t(1'b0);
    for (int i = 0; i < 4; i++) bit_t(logic'((8'h0F >> i) & 8'h01));
    i_rx = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; i_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if ({rd_if.o_empty, rd_if.o_full} !== 2'b10) $display("FAIL midreset_flags: empty/full=%b want 10", {rd_if.o_empty, rd_if.o_full}); else pass_cnt++;
    total++; if (rd_if.o_count !== 5'd0) $display("FAIL midreset_count: got %0d want 0", rd_if.o_count); else pass_cnt++;
    total++; if (rd_if.o_rd_data !== 8'h00) $display("FAIL midreset_rd_data: got %h want 00", rd_if.o_rd_data); else pass_cnt++;
    fe0 = n_fe;
    repeat (12 * 16) @(negedge clk);
    total++; if ({rd_if.o_count, 32'(n_fe - fe0)} !== {5'd0, 32'd0})
      $display("FAIL midreset_quiet: count=%0d fe=%0d want 0 0", rd_if.o_count, n_fe - fe0);
    else pass_cnt++;
    rd_if.i_rd_en = 1'b1;
    #1;
    total++; if (rd_if.o_underflow !== 1'b1) $display("FAIL underflow_pulse: got %b want 1", rd_if.o_underflow); else pass_cnt++;
    @(negedge clk);
    rd_if.i_rd_en = 1'b0;
    #1;
    total++; if ({rd_if.o_underflow, rd_if.o_count} !== {1'b0, 5'd0})
      $display("FAIL underflow_after: uf=%b count=%0d want 0 0", rd_if.o_underflow, rd_if.o_count);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; i_rx = 1'b1; rd_if.i_rd_en = 1'b0;
    baud_divisor = 16'd16; i_parity_type = 2'b00;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_parity();
    test_framing_break();
    test_false_start();
    test_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- UART receive path: serial line in, bytes out through an internal receive FIFO, drained by a host-side reader with a pop handshake.
- Counterpart to the existing transmit path (TX FIFO + serializer). A loopback of o_tx into i_rx yields the same bytes in the same order.
- Shares baud_divisor and parity-type encoding with the transmitter. Flags framing, parity and overrun errors per frame.

Parameters:
- DEPTH, 16, receive FIFO entries; power of 2, minimum 4.
- ALMOST_FULL_THR, 14, o_almostfull asserts when o_count >= this value.
- ALMOST_EMPTY_THR, 1, o_almostempty asserts when o_count <= this value and o_count != 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_rx  in  1  serial line; idle high.
- baud_divisor  in  16  clk cycles per bit (434 = 115200 baud at 50 MHz); valid range 4..65535.
- i_parity_type  in  2  00 none, 01 even, 10 odd, 11 none.
- i_rd_en  in  1  pop the head entry.
- o_rd_data  out  8  head entry (first-word-fall-through); valid when o_empty=0.
- o_empty  out  1  FIFO empty.
- o_full  out  1  FIFO full.
- o_almostfull  out  1  o_count >= ALMOST_FULL_THR.
- o_almostempty  out  1  1 <= o_count <= ALMOST_EMPTY_THR.
- o_count  out  $clog2(DEPTH)+1  stored entries.
- o_underflow  out  1  1-cycle pulse on i_rd_en while empty.
- o_framing_error  out  1  1-cycle pulse when the stop bit is sampled low.
- o_parity_error  out  1  1-cycle pulse on parity mismatch.
- o_overrun_error  out  1  1-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - Sync flops = 1; FSM = IDLE; FIFO pointers and count = 0.
  - o_empty = 1; o_rd_data = 0; all other outputs = 0.
- Reset is honoured mid-frame and mid-read: the partial frame is discarded and the FIFO is cleared.
- Input conditioning: i_rx passes through a 2-flop synchronizer (rx_s); start detection adds 2 cycles of latency.
- Configuration capture: baud_divisor and i_parity_type are latched on start detection. Changes mid-frame take effect from the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: when rx_s = 0, load bit counter = 0, go to START.
  - START: sample at count = (div>>1)-1. If rx_s = 1, it is a false start: return to IDLE with no flag. Otherwise reset the counter and go to DATA.
  - DATA: sample every div cycles, LSB first, 8 bits. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: sample once.
    - Even: XOR of data and parity bit must be 0.
    - Odd: XOR of data and parity bit must be 1.
    - Record a mismatch internally.
  - STOP: sample once.
    - rx_s = 0: pulse o_framing_error, discard the byte, go to WAIT_IDLE.
    - rx_s = 1: write the byte to the FIFO if not full, else pulse o_overrun_error and drop it. Pulse o_parity_error in the same cycle if a mismatch was recorded; a parity-errored byte is still written. Go to IDLE.
  - WAIT_IDLE: hold until rx_s = 1 (break condition), then go to IDLE. No further flags during a break.
- Latency: the FIFO write occurs on the stop-bit sample cycle; o_empty and o_count update on the next clock.
- Back-to-back frames: a start bit immediately after stop is detected with no idle gap.
- FIFO:
  - Circular buffer with wrap-around pointers; o_rd_data = mem[rd_ptr] combinationally from registered state.
  - Pop while empty: ignored, o_underflow pulses.
  - Simultaneous write and pop while full: both occur, count unchanged, no overrun.
  - Simultaneous write and pop while empty: the write occurs and the pop is an underflow.
- Error pulses are independent; framing excludes parity and overrun for the same frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit is the majority of 3 rx_s samples taken at the nominal sample point −1, 0 and +1 cycles; the decision is made at the +1 point. The false-start check also uses the vote.
- Undefined: a single sample at the nominal point.
- Flag timing shifts by +1 cycle when the macro is defined.

Test Plan:
- Loopback: div = 434, parity 01, drive 0xA5, 0x3C, 0xFF, 0x00 -> FIFO pops return the same 4 bytes in order; o_count reaches 4; no error pulses.
- Parity: div = 16, parity 10 (odd), send 0x01 with parity bit 1 (wrong) -> o_parity_error pulses once; 0x01 is stored.
- Framing and break: div = 16, send 0x55 with stop = 0, then hold the line low for 40 bit times -> exactly one o_framing_error; FIFO stays empty; next frame 0x12 is received correctly.
- Overrun: DEPTH = 16, send 17 bytes with no reads -> o_full = 1 after 16; o_overrun_error pulses on the 17th; a pop returns the first byte. Full + pop on the write cycle -> no overrun.
- False start and glitch: a 3-cycle low pulse at div = 16 -> no write, no flag. With UART_RX_MAJORITY_VOTE_EN, a 1-cycle inverted glitch at the sample point of a data bit -> byte still correct.
- Reset mid-frame and underflow: assert rst during bit 4 -> outputs at reset values, FIFO empty. i_rd_en while empty -> o_underflow pulses for 1 cycle; o_count stays 0.
